// File: rtl/ham_weight_gen.sv
// Enumerates every WIDTH-bit pattern of popcount k in ascending order over a valid/ready stream.
// A candidate counter walks 0..all-ones; matches are parked in HOLD until the consumer takes them.
module ham_weight_gen #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CW-1:0]    k,
   output logic             busy,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             done,
   output logic             err,
   output logic [WIDTH:0]   n_emitted
);

   typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

   localparam logic [CW-1:0] WMAX = CW'(WIDTH);

   state_t           state_q;
   logic [WIDTH-1:0] cand_q;
   logic [WIDTH-1:0] cand_d;
   logic [CW-1:0]    k_q;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic [WIDTH:0]   cnt_q;
   logic [WIDTH:0]   cnt_d;
   logic             match;
   logic             last_cand;

   function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   assign cand_d    = cand_q + WIDTH'(1);
   assign cnt_d     = cnt_q + (WIDTH + 1)'(1);
   assign match     = (popcount(cand_q) == k_q);
   assign last_cand = &cand_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cand_q  <= '0;
         k_q     <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  k_q    <= k;
                  cand_q <= '0;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
                  if (k > WMAX) begin
                     err_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     err_q   <= 1'b0;
                     state_q <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (match) begin
                  data_q  <= cand_q;
                  valid_q <= 1'b1;
                  state_q <= HOLD;
               end else if (last_cand) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cand_q <= cand_d;
               end
            end
            HOLD: begin
               // Resume from the next value so the all-ones pattern never wraps back to 0.
               if (out_ready) begin
                  valid_q <= 1'b0;
                  cnt_q   <= cnt_d;
                  if (last_cand) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     cand_q  <= cand_d;
                     state_q <= SCAN;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign done      = done_q;
   assign err       = err_q;
   assign n_emitted = cnt_q;

endmodule

// File: tb/tb_ham_weight_gen.sv
// Directed bench for ham_weight_gen (WIDTH=8): enumeration order, stalls, latency, error path, reset.
module tb_ham_weight_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] k;
   logic       busy;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       done;
   logic       err;
   logic [8:0] n_emitted;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] beats[$];
   int         done_cnt;
   logic [8:0] nemit_at_done;
   int         stall_bad;
   bit         timed_out;

   ham_weight_gen #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .k         (k),
      .busy      (busy),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .done      (done),
      .err       (err),
      .n_emitted (n_emitted)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at a negedge; start is seen by the following posedge.
   task automatic do_start(input logic [3:0] kv);
      start = 1'b1;
      k     = kv;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Samples at negedges, records handshaked beats, done pulses and stall violations.
   task automatic collect(input int max_cyc, input bit rand_rdy, input int stop_beats);
      bit         prev_stall;
      logic [7:0] prev_data;
      bit         seen_done;
      int         tail;
      beats.delete();
      done_cnt      = 0;
      stall_bad     = 0;
      timed_out     = 1'b0;
      nemit_at_done = '0;
      prev_stall    = 1'b0;
      prev_data     = '0;
      seen_done     = 1'b0;
      tail          = 0;
      for (int c = 0; c < max_cyc; c++) begin
         if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stall_bad++;
         if (done === 1'b1) begin
            done_cnt++;
            nemit_at_done = n_emitted;
            seen_done     = 1'b1;
         end
         out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid === 1'b1 && out_ready) beats.push_back(out_data);
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_data  = out_data;
         if (stop_beats > 0 && beats.size() == stop_beats) return;
         if (seen_done) tail++;
         if (tail >= 3) return;
         @(negedge clk);
      end
      timed_out = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      start     = 1'b0;
      k         = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", out_data); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      n_checks++; if (n_emitted !== 9'd0) begin n_fail++; $display("FAIL reset_nemit: got %0d want 0", n_emitted); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_k0();
      out_ready = 1'b1;
      do_start(4'd0);
      collect(1000, 1'b0, 0);
      n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL k0_timeout: got %b want 0", timed_out); end
      n_checks++; if (beats.size() != 1) begin n_fail++; $display("FAIL k0_count: got %0d want 1", beats.size()); end
      if (beats.size() > 0) begin
         n_checks++; if (beats[0] !== 8'h00) begin n_fail++; $display("FAIL k0_beat: got %h want 00", beats[0]); end
      end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL k0_done_cnt: got %0d want 1", done_cnt); end
      n_checks++; if (nemit_at_done !== 9'd1) begin n_fail++; $display("FAIL k0_nemit: got %0d want 1", nemit_at_done); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL k0_err: got %b want 0", err); end
   endtask

   task automatic test_k1_busy_start();
      logic [7:0] exp;
      out_ready = 1'b0;
      do_start(4'd1);
      repeat (4) @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin n_fail++; $display("FAIL k1_first_hold: got v=%b d=%h want v=1 d=01", out_valid, out_data); end
      start = 1'b1;
      k     = 4'd0;
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin n_fail++; $display("FAIL k1_busy_start: got v=%b d=%h want v=1 d=01", out_valid, out_data); end
      collect(1000, 1'b0, 0);
      n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL k1_timeout: got %b want 0", timed_out); end
      n_checks++; if (beats.size() != 8) begin n_fail++; $display("FAIL k1_count: got %0d want 8", beats.size()); end
      exp = 8'h01;
      for (int i = 0; i < beats.size() && i < 8; i++) begin
         n_checks++; if (beats[i] !== exp) begin n_fail++; $display("FAIL k1_beat%0d: got %h want %h", i, beats[i], exp); end
         exp = exp << 1;
      end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL k1_done_cnt: got %0d want 1", done_cnt); end
      n_checks++; if (nemit_at_done !== 9'd8) begin n_fail++; $display("FAIL k1_nemit: got %0d want 8", nemit_at_done); end
   endtask

   task automatic test_k8_latency();
      int n;
      out_ready = 1'b1;
      do_start(4'd8);
      n = 1;
      while (out_valid !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      n_checks++; if (n != 257) begin n_fail++; $display("FAIL k8_latency: got %0d want 257", n); end
      n_checks++; if (out_data !== 8'hFF) begin n_fail++; $display("FAIL k8_data: got %h want ff", out_data); end
      @(negedge clk);
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL k8_done: got %b want 1", done); end
      n_checks++; if (n_emitted !== 9'd1) begin n_fail++; $display("FAIL k8_nemit: got %0d want 1", n_emitted); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL k8_valid_after: got %b want 0", out_valid); end
      @(negedge clk);
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL k8_idle: got busy=%b done=%b want 0 0", busy, done); end
   endtask

   task automatic test_k4_stall();
      collect(4000, 1'b1, 0);
      out_ready = 1'b1;
      n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL k4_timeout: got %b want 0", timed_out); end
      n_checks++; if (beats.size() != 70) begin n_fail++; $display("FAIL k4_count: got %0d want 70", beats.size()); end
      n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL k4_stall_stable: got %0d violations want 0", stall_bad); end
      n_checks++; if (nemit_at_done !== 9'd70) begin n_fail++; $display("FAIL k4_nemit: got %0d want 70", nemit_at_done); end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL k4_done_cnt: got %0d want 1", done_cnt); end
      if (beats.size() == 70) begin
         n_checks++; if (beats[0] !== 8'h0F) begin n_fail++; $display("FAIL k4_first: got %h want 0f", beats[0]); end
         n_checks++; if (beats[69] !== 8'hF0) begin n_fail++; $display("FAIL k4_last: got %h want f0", beats[69]); end
      end
      for (int i = 0; i < beats.size(); i++) begin
         n_checks++; if ($countones(beats[i]) != 4) begin n_fail++; $display("FAIL k4_weight%0d: got %h want popcount 4", i, beats[i]); end
         if (i > 0) begin
            n_checks++; if (!(beats[i] > beats[i-1])) begin n_fail++; $display("FAIL k4_order%0d: got %h after %h want ascending", i, beats[i], beats[i-1]); end
         end
      end
   endtask

   task automatic test_k4_run();
      do_start(4'd4);
      test_k4_stall();
   endtask

   task automatic test_err();
      out_ready = 1'b1;
      do_start(4'd9);
      n_checks++; if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL err_done: got done=%b err=%b want 1 1", done, err); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err_valid: got %b want 0", out_valid); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL err_after: got done=%b busy=%b err=%b want 0 0 1", done, busy, err); end
      do_start(4'd2);
      n_checks++; if (err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL err_clear: got err=%b busy=%b want 0 1", err, busy); end
      collect(1000, 1'b0, 0);
      n_checks++; if (nemit_at_done !== 9'd28) begin n_fail++; $display("FAIL err_k2_nemit: got %0d want 28", nemit_at_done); end
   endtask

   task automatic test_midrun_reset();
      out_ready = 1'b1;
      do_start(4'd3);
      collect(1000, 1'b0, 5);
      n_checks++; if (beats.size() != 5) begin n_fail++; $display("FAIL mr_pre_count: got %0d want 5", beats.size()); end
      if (beats.size() == 5) begin
         n_checks++; if (beats[4] !== 8'h13) begin n_fail++; $display("FAIL mr_pre_beat4: got %h want 13", beats[4]); end
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++; if ({busy, out_valid, done, err} !== 4'b0000 || out_data !== 8'h00 || n_emitted !== 9'd0) begin
         n_fail++; $display("FAIL mr_reset: got busy=%b v=%b done=%b err=%b d=%h n=%0d want all 0", busy, out_valid, done, err, out_data, n_emitted);
      end
      rst_n = 1'b1;
      @(negedge clk);
      do_start(4'd2);
      collect(1000, 1'b0, 0);
      n_checks++; if (beats.size() != 28) begin n_fail++; $display("FAIL mr_count: got %0d want 28", beats.size()); end
      if (beats.size() == 28) begin
         n_checks++; if (beats[0] !== 8'h03) begin n_fail++; $display("FAIL mr_first: got %h want 03", beats[0]); end
         n_checks++; if (beats[27] !== 8'hC0) begin n_fail++; $display("FAIL mr_last: got %h want c0", beats[27]); end
      end
      n_checks++; if (nemit_at_done !== 9'd28) begin n_fail++; $display("FAIL mr_nemit: got %0d want 28", nemit_at_done); end
   endtask

   initial begin
      test_reset();
      test_k0();
      test_k1_busy_start();
      test_k8_latency();
      @(negedge clk);
      test_k4_run();
      test_err();
      test_midrun_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
